// File: rtl/pkt_merger.sv
// pkt_merger: merges the data-path and control-path AXI-Stream inputs into a
// single registered egress stream. Arbitration happens only between packets
// (round-robin on contention), so a packet is never interleaved with another.
// The output register is a one-deep skid-free stage: an input is ready only
// when the output register is empty or is being drained this cycle.
module pkt_merger #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    // Internal width of the packet counters; they are zero-extended to 32 bits
    // on the ports. Narrow builds make the wrap-around cheap to exercise.
    parameter int C_CNT_WIDTH          = 32
) (
    input  logic                              clk,
    input  logic                              aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
    input  logic                              ctrl_s_axis_tvalid,
    input  logic                              ctrl_s_axis_tlast,
    output logic                              ctrl_s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [31:0]                       data_pkt_cnt,
    output logic [31:0]                       ctrl_pkt_cnt
);

    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEND_DATA = 2'd1;
    localparam logic [1:0] SEND_CTRL = 2'd2;

    localparam logic GRANT_DATA = 1'b0;
    localparam logic GRANT_CTRL = 1'b1;

    logic [1:0]                       state_q, state_d;
    logic                             last_grant_q, last_grant_d;

    logic [C_S_AXIS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [KW-1:0]                    tkeep_q, tkeep_d;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  tuser_q, tuser_d;
    logic                             tvalid_q, tvalid_d;
    logic                             tlast_q, tlast_d;

    logic [C_CNT_WIDTH-1:0]           data_cnt_q, data_cnt_d;
    logic [C_CNT_WIDTH-1:0]           ctrl_cnt_q, ctrl_cnt_d;

    logic                             out_ready;
    logic                             data_acc;
    logic                             ctrl_acc;

    // The output register can take a new beat when empty or being drained.
    assign out_ready          = !tvalid_q || m_axis_tready;
    assign s_axis_tready      = (state_q == SEND_DATA) && out_ready;
    assign ctrl_s_axis_tready = (state_q == SEND_CTRL) && out_ready;
    assign data_acc           = s_axis_tready && s_axis_tvalid;
    assign ctrl_acc           = ctrl_s_axis_tready && ctrl_s_axis_tvalid;

    // Packet-level arbitration: grant in IDLE, release only after tlast.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (s_axis_tvalid && ctrl_s_axis_tvalid) begin
                    if (last_grant_q == GRANT_CTRL) begin
                        state_d      = SEND_DATA;
                        last_grant_d = GRANT_DATA;
                    end else begin
                        state_d      = SEND_CTRL;
                        last_grant_d = GRANT_CTRL;
                    end
                end else if (s_axis_tvalid) begin
                    state_d = SEND_DATA;
                end else if (ctrl_s_axis_tvalid) begin
                    state_d = SEND_CTRL;
                end
            end
            SEND_DATA: begin
                if (data_acc && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            SEND_CTRL: begin
                if (ctrl_acc && ctrl_s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: load the accepted beat, otherwise hold or empty.
    always_comb begin
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (data_acc) begin
            tdata_d  = s_axis_tdata;
            tkeep_d  = s_axis_tkeep;
            tuser_d  = s_axis_tuser;
            tlast_d  = s_axis_tlast;
            tvalid_d = 1'b1;
        end else if (ctrl_acc) begin
            tdata_d  = ctrl_s_axis_tdata;
            tkeep_d  = ctrl_s_axis_tkeep;
            tuser_d  = ctrl_s_axis_tuser;
            tlast_d  = ctrl_s_axis_tlast;
            tvalid_d = 1'b1;
        end else if (out_ready) begin
            tvalid_d = 1'b0;
        end
    end

    // Packet counters advance when the tlast beat enters the output register.
    always_comb begin
        data_cnt_d = data_cnt_q;
        ctrl_cnt_d = ctrl_cnt_q;
        if (data_acc && s_axis_tlast) begin
            data_cnt_d = data_cnt_q + 1'b1;
        end
        if (ctrl_acc && ctrl_s_axis_tlast) begin
            ctrl_cnt_d = ctrl_cnt_q + 1'b1;
        end
    end

    // State, output stage and counters; reset drops any partial packet.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_CTRL;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tuser_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            data_cnt_q   <= '0;
            ctrl_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tuser_q      <= tuser_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            data_cnt_q   <= data_cnt_d;
            ctrl_cnt_q   <= ctrl_cnt_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

    assign data_pkt_cnt  = 32'(data_cnt_q);
    assign ctrl_pkt_cnt  = 32'(ctrl_cnt_q);

endmodule
